// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the Wishbone arbiter and the address-decoding switch:
// FSM encodings, cycle-type constants and width helpers.
package bus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Vectors must be at least one bit wide even when clog2 collapses to zero.
    function automatic int cwidth(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of the NMASTERS upstream Wishbone ports and the single downstream port.
// The slave modport is the arbiter's view; the master modport is the environment's.
interface bus_arbiter_if #(
    parameter int NMASTERS = 2
);

    logic [NMASTERS*32-1:0] master_addr;
    logic [NMASTERS*32-1:0] master_wdata;
    logic [NMASTERS*4-1:0]  master_sel;
    logic [NMASTERS-1:0]    master_we;
    logic [NMASTERS-1:0]    master_cyc;
    logic [NMASTERS-1:0]    master_stb;
    logic [NMASTERS*3-1:0]  master_cti;
    logic [NMASTERS*2-1:0]  master_bte;
    logic [NMASTERS*32-1:0] master_rdata;
    logic [NMASTERS-1:0]    master_ack;
    logic [NMASTERS-1:0]    master_err;

    logic [31:0] slave_addr;
    logic [31:0] slave_wdata;
    logic [3:0]  slave_sel;
    logic        slave_we;
    logic        slave_cyc;
    logic        slave_stb;
    logic [2:0]  slave_cti;
    logic [1:0]  slave_bte;
    logic [31:0] slave_rdata;
    logic        slave_ack;
    logic        slave_err;

    modport slave (
        input  master_addr, master_wdata, master_sel, master_we,
        input  master_cyc, master_stb, master_cti, master_bte,
        output master_rdata, master_ack, master_err,
        output slave_addr, slave_wdata, slave_sel, slave_we,
        output slave_cyc, slave_stb, slave_cti, slave_bte,
        input  slave_rdata, slave_ack, slave_err
    );

    modport master (
        output master_addr, master_wdata, master_sel, master_we,
        output master_cyc, master_stb, master_cti, master_bte,
        input  master_rdata, master_ack, master_err,
        input  slave_addr, slave_wdata, slave_sel, slave_we,
        input  slave_cyc, slave_stb, slave_cti, slave_bte,
        output slave_rdata, slave_ack, slave_err
    );

endinterface

// File: rtl/bus_arbiter_rr_priority.sv
// Round-robin priority picker: the first requester at or after i_ptr wins,
// reported both one-hot and encoded.
module rr_priority
    import bus_arbiter_pkg::*;
#(
    parameter  int NMASTERS = 2,
    localparam int PW       = cwidth(NMASTERS)
) (
    input  logic [NMASTERS-1:0] i_req,
    input  logic [PW-1:0]       i_ptr,
    output logic [NMASTERS-1:0] o_onehot,
    output logic [PW-1:0]       o_idx,
    output logic                o_valid
);

    int w_cand;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_cand   = 0;
        for (int i = 0; i < NMASTERS; i++) begin
            w_cand = (int'(i_ptr) + i) % NMASTERS;
            if (!o_valid && i_req[w_cand]) begin
                o_valid          = 1'b1;
                o_idx            = PW'(w_cand);
                o_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin Wishbone B4 arbiter: grants one master for its whole cyc assertion
// and aborts with err when the selected slave stays silent for TIMEOUT cycles.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NMASTERS = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    bus_arbiter_if.slave  bus
);

    localparam int GW = cwidth(NMASTERS);
    localparam int CW = cwidth(TIMEOUT + 1);
    localparam logic [CW-1:0] EXPIRE_AT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [GW-1:0] LAST_IDX  = GW'(NMASTERS - 1);

    logic [1:0]          r_state;
    logic [GW-1:0]       r_grant;
    logic [GW-1:0]       r_ptr;
    logic [CW-1:0]       r_count;
    logic                r_errPulse;

    logic [NMASTERS-1:0] w_onehot;
    logic [GW-1:0]       w_winner;
    logic                w_valid;
    logic                w_grantCyc;
    logic                w_grantStb;
    logic                w_busy;
    logic                w_ackOrErr;
    logic                w_expire;
    logic [GW-1:0]       w_nextPtr;

    rr_priority #(
        .NMASTERS (NMASTERS)
    ) u_rr_priority (
        .i_req    (bus.master_cyc),
        .i_ptr    (r_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_winner),
        .o_valid  (w_valid)
    );

    assign w_grantCyc = bus.master_cyc[r_grant];
    assign w_grantStb = bus.master_stb[r_grant];
    assign w_busy     = (r_state == ST_BUSY);
    assign w_ackOrErr = bus.slave_ack | bus.slave_err;
    assign w_nextPtr  = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;

    // An ack or err arriving in the expiry cycle wins over the watchdog.
    assign w_expire = (TIMEOUT != 0) && bus.slave_stb && !w_ackOrErr && (r_count == EXPIRE_AT);

    assign bus.slave_cyc   = w_busy & w_grantCyc;
    assign bus.slave_stb   = w_busy & w_grantCyc & w_grantStb;
    assign bus.slave_addr  = bus.master_addr[32*int'(r_grant) +: 32];
    assign bus.slave_wdata = bus.master_wdata[32*int'(r_grant) +: 32];
    assign bus.slave_sel   = bus.master_sel[4*int'(r_grant) +: 4];
    assign bus.slave_we    = bus.master_we[r_grant];
    assign bus.slave_cti   = bus.master_cti[3*int'(r_grant) +: 3];
    assign bus.slave_bte   = bus.master_bte[2*int'(r_grant) +: 2];
    assign bus.master_rdata = {NMASTERS{bus.slave_rdata}};

    always_comb begin
        bus.master_ack = '0;
        bus.master_err = '0;
        if (w_busy) begin
            bus.master_ack[r_grant] = bus.slave_ack;
            bus.master_err[r_grant] = bus.slave_err;
        end else if (r_errPulse) begin
            bus.master_err[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (!bus.slave_stb || w_ackOrErr || (TIMEOUT == 0)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // r_errPulse marks the first ABORT cycle only, so err is a single-cycle pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_ptr      <= '0;
            r_errPulse <= 1'b0;
        end else begin
            r_errPulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_grant <= w_winner;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!w_grantCyc) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= w_nextPtr;
                    end else if (w_expire) begin
                        r_state    <= ST_ABORT;
                        r_errPulse <= 1'b1;
                    end
                end
                ST_ABORT: begin
                    if (!w_grantCyc) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= w_nextPtr;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with two masters and an 8-cycle watchdog.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int NM  = 2;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rstN;
    int   total = 0;
    int   bad   = 0;

    bus_arbiter_if #(.NMASTERS(NM)) bus ();

    bus_arbiter #(
        .NMASTERS (NM),
        .TIMEOUT  (TMO)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rstN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic setM(input int m, input logic cyc, input logic stb,
                        input logic [31:0] addr, input logic [2:0] cti);
        bus.master_cyc[m]          = cyc;
        bus.master_stb[m]          = stb;
        bus.master_addr[m*32 +: 32] = addr;
        bus.master_cti[m*3 +: 3]    = cti;
    endtask

    task automatic clearAll();
        bus.master_addr  = '0;
        bus.master_wdata = '0;
        bus.master_sel   = '0;
        bus.master_we    = '0;
        bus.master_cyc   = '0;
        bus.master_stb   = '0;
        bus.master_cti   = '0;
        bus.master_bte   = '0;
        bus.slave_rdata  = '0;
        bus.slave_ack    = 1'b0;
        bus.slave_err    = 1'b0;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        clearAll();
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        clearAll();
        setM(0, 1'b0, 1'b0, 32'h1111_0000, CTI_CLASSIC);
        setM(1, 1'b0, 1'b0, 32'h2222_0000, CTI_CLASSIC);
        #3;
        total++;
        if (bus.slave_cyc !== 1'b0 || bus.slave_stb !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_cyc_stb got=%b%b exp=00", bus.slave_cyc, bus.slave_stb);
        end
        total++;
        if (bus.master_ack !== 2'b00 || bus.master_err !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_ack_err got ack=%b err=%b exp=00/00", bus.master_ack, bus.master_err);
        end
        total++;
        if (bus.slave_addr !== 32'h1111_0000) begin
            bad++;
            $display("[TB] FAIL reset_grant0_addr got=%h exp=11110000", bus.slave_addr);
        end
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    task automatic test_single_master();
        setM(0, 1'b1, 1'b1, 32'h0000_1000, CTI_CLASSIC);
        settle();
        total++;
        if (bus.slave_cyc !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_latency got=%b exp=0", bus.slave_cyc);
        end
        step();
        settle();
        total++;
        if (bus.slave_cyc !== 1'b1 || bus.slave_addr !== 32'h0000_1000) begin
            bad++;
            $display("[TB] FAIL single_grant got cyc=%b addr=%h exp 1/00001000", bus.slave_cyc, bus.slave_addr);
        end
        total++;
        if (bus.master_ack !== 2'b00) begin
            bad++;
            $display("[TB] FAIL single_early_ack got=%b exp=00", bus.master_ack);
        end
        step();
        bus.slave_ack   = 1'b1;
        bus.slave_rdata = 32'hDEAD_BEEF;
        settle();
        total++;
        if (bus.master_ack !== 2'b01) begin
            bad++;
            $display("[TB] FAIL single_ack got=%b exp=01", bus.master_ack);
        end
        total++;
        if (bus.master_rdata !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
            bad++;
            $display("[TB] FAIL single_rdata got=%h exp=deadbeefdeadbeef", bus.master_rdata);
        end
        step();
        bus.slave_ack = 1'b0;
        setM(0, 1'b0, 1'b0, 32'h0000_1000, CTI_CLASSIC);
        settle();
        total++;
        if (bus.master_ack !== 2'b00 || bus.slave_cyc !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_release got ack=%b cyc=%b exp 00/0", bus.master_ack, bus.slave_cyc);
        end
        step();
    endtask

    task automatic test_contention();
        doReset();
        setM(0, 1'b1, 1'b1, 32'h0000_00A0, CTI_CLASSIC);
        setM(1, 1'b1, 1'b1, 32'h0000_00B0, CTI_CLASSIC);
        step();
        settle();
        total++;
        if (bus.slave_cyc !== 1'b1 || bus.slave_addr !== 32'h0000_00A0) begin
            bad++;
            $display("[TB] FAIL cont_first_m0 got cyc=%b addr=%h exp 1/000000a0", bus.slave_cyc, bus.slave_addr);
        end
        bus.slave_ack = 1'b1;
        settle();
        total++;
        if (bus.master_ack !== 2'b01) begin
            bad++;
            $display("[TB] FAIL cont_ack_m0 got=%b exp=01", bus.master_ack);
        end
        step();
        bus.slave_ack = 1'b0;
        setM(0, 1'b0, 1'b0, 32'h0000_00A0, CTI_CLASSIC);
        settle();
        total++;
        if (bus.slave_cyc !== 1'b0) begin
            bad++;
            $display("[TB] FAIL cont_drop got=%b exp=0", bus.slave_cyc);
        end
        step();
        settle();
        total++;
        if (bus.slave_cyc !== 1'b0) begin
            bad++;
            $display("[TB] FAIL cont_dead_cycle got=%b exp=0", bus.slave_cyc);
        end
        step();
        settle();
        total++;
        if (bus.slave_cyc !== 1'b1 || bus.slave_addr !== 32'h0000_00B0) begin
            bad++;
            $display("[TB] FAIL cont_second_m1 got cyc=%b addr=%h exp 1/000000b0", bus.slave_cyc, bus.slave_addr);
        end
        bus.slave_ack = 1'b1;
        settle();
        total++;
        if (bus.master_ack !== 2'b10) begin
            bad++;
            $display("[TB] FAIL cont_ack_m1 got=%b exp=10", bus.master_ack);
        end
        step();
        bus.slave_ack = 1'b0;
        setM(1, 1'b0, 1'b0, 32'h0000_00B0, CTI_CLASSIC);
        step();
        setM(0, 1'b1, 1'b1, 32'h0000_00A4, CTI_CLASSIC);
        setM(1, 1'b1, 1'b1, 32'h0000_00B4, CTI_CLASSIC);
        step();
        settle();
        total++;
        if (bus.slave_cyc !== 1'b1 || bus.slave_addr !== 32'h0000_00A4) begin
            bad++;
            $display("[TB] FAIL cont_wrap_m0 got cyc=%b addr=%h exp 1/000000a4", bus.slave_cyc, bus.slave_addr);
        end
        bus.slave_ack = 1'b1;
        step();
        bus.slave_ack = 1'b0;
        setM(0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        setM(1, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        step();
    endtask

    task automatic test_burst_lock();
        logic [2:0]  expCti;
        logic [31:0] expAddr;
        setM(1, 1'b1, 1'b1, 32'h0000_2000, CTI_INCR);
        step();
        setM(0, 1'b1, 1'b1, 32'h0000_3000, CTI_CLASSIC);
        for (int k = 0; k < 4; k++) begin
            expCti  = (k == 3) ? CTI_EOB : CTI_INCR;
            expAddr = 32'h0000_2000 + 32'(4 * k);
            setM(1, 1'b1, 1'b1, expAddr, expCti);
            bus.slave_ack   = 1'b1;
            bus.slave_rdata = 32'(k);
            settle();
            total++;
            if (bus.master_ack !== 2'b10 || bus.slave_addr !== expAddr || bus.slave_cti !== expCti) begin
                bad++;
                $display("[TB] FAIL burst_beat%0d got ack=%b addr=%h cti=%b exp 10/%h/%b",
                         k, bus.master_ack, bus.slave_addr, bus.slave_cti, expAddr, expCti);
            end
            step();
        end
        bus.slave_ack = 1'b0;
        setM(1, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        settle();
        total++;
        if (bus.slave_cyc !== 1'b0 || bus.master_ack !== 2'b00) begin
            bad++;
            $display("[TB] FAIL burst_release got cyc=%b ack=%b exp 0/00", bus.slave_cyc, bus.master_ack);
        end
        step();
        settle();
        total++;
        if (bus.slave_cyc !== 1'b0) begin
            bad++;
            $display("[TB] FAIL burst_dead_cycle got=%b exp=0", bus.slave_cyc);
        end
        step();
        settle();
        total++;
        if (bus.slave_cyc !== 1'b1 || bus.slave_addr !== 32'h0000_3000) begin
            bad++;
            $display("[TB] FAIL burst_m0_after got cyc=%b addr=%h exp 1/00003000", bus.slave_cyc, bus.slave_addr);
        end
        bus.slave_ack = 1'b1;
        settle();
        total++;
        if (bus.master_ack !== 2'b01) begin
            bad++;
            $display("[TB] FAIL burst_m0_ack got=%b exp=01", bus.master_ack);
        end
        step();
        bus.slave_ack = 1'b0;
        setM(0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        step();
    endtask

    task automatic test_timeout();
        doReset();
        setM(0, 1'b1, 1'b1, 32'h0000_4000, CTI_CLASSIC);
        for (int k = 1; k <= TMO; k++) begin
            step();
            settle();
            total++;
            if ({bus.master_err, bus.slave_cyc} !== 3'b001) begin
                bad++;
                $display("[TB] FAIL tmo_wait%0d got err=%b cyc=%b exp 00/1", k, bus.master_err, bus.slave_cyc);
            end
        end
        step();
        settle();
        total++;
        if (bus.master_err !== 2'b01) begin
            bad++;
            $display("[TB] FAIL tmo_err_pulse got=%b exp=01", bus.master_err);
        end
        total++;
        if (bus.slave_cyc !== 1'b0 || bus.slave_stb !== 1'b0 || bus.master_ack !== 2'b00) begin
            bad++;
            $display("[TB] FAIL tmo_abort_bus got cyc=%b stb=%b ack=%b exp 0/0/00",
                     bus.slave_cyc, bus.slave_stb, bus.master_ack);
        end
        step();
        settle();
        total++;
        if (bus.master_err !== 2'b00 || bus.slave_cyc !== 1'b0) begin
            bad++;
            $display("[TB] FAIL tmo_single_pulse got err=%b cyc=%b exp 00/0", bus.master_err, bus.slave_cyc);
        end
        step();
        setM(0, 1'b0, 1'b0, 32'h0000_4000, CTI_CLASSIC);
        step();
        setM(1, 1'b1, 1'b1, 32'h0000_4400, CTI_CLASSIC);
        step();
        settle();
        total++;
        if (bus.slave_cyc !== 1'b1 || bus.slave_addr !== 32'h0000_4400) begin
            bad++;
            $display("[TB] FAIL tmo_back_to_idle got cyc=%b addr=%h exp 1/00004400", bus.slave_cyc, bus.slave_addr);
        end
        bus.slave_ack = 1'b1;
        step();
        bus.slave_ack = 1'b0;
        setM(1, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        step();
    endtask

    task automatic test_expiry_race();
        doReset();
        setM(0, 1'b1, 1'b1, 32'h0000_5000, CTI_CLASSIC);
        repeat (TMO - 1) step();
        step();
        bus.slave_ack = 1'b1;
        settle();
        total++;
        if (bus.master_ack !== 2'b01 || bus.master_err !== 2'b00) begin
            bad++;
            $display("[TB] FAIL race_ack_wins got ack=%b err=%b exp 01/00", bus.master_ack, bus.master_err);
        end
        step();
        bus.slave_ack = 1'b0;
        settle();
        total++;
        if (bus.slave_cyc !== 1'b1 || bus.master_err !== 2'b00) begin
            bad++;
            $display("[TB] FAIL race_stays_busy got cyc=%b err=%b exp 1/00", bus.slave_cyc, bus.master_err);
        end
        repeat (TMO - 1) step();
        setM(0, 1'b0, 1'b0, 32'h0000_5000, CTI_CLASSIC);
        settle();
        total++;
        if (bus.slave_cyc !== 1'b0) begin
            bad++;
            $display("[TB] FAIL race_drop_cyc got=%b exp=0", bus.slave_cyc);
        end
        step();
        settle();
        total++;
        if (bus.master_err !== 2'b00) begin
            bad++;
            $display("[TB] FAIL race_drop_no_err got=%b exp=00", bus.master_err);
        end
        setM(0, 1'b1, 1'b1, 32'h0000_5100, CTI_CLASSIC);
        step();
        settle();
        total++;
        if (bus.slave_cyc !== 1'b1 || bus.slave_addr !== 32'h0000_5100) begin
            bad++;
            $display("[TB] FAIL race_drop_idle got cyc=%b addr=%h exp 1/00005100", bus.slave_cyc, bus.slave_addr);
        end
        bus.slave_ack = 1'b1;
        step();
        bus.slave_ack = 1'b0;
        setM(0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        step();
    endtask

    task automatic test_reset_mid_burst();
        doReset();
        setM(0, 1'b0, 1'b0, 32'h0000_7000, CTI_CLASSIC);
        setM(1, 1'b1, 1'b1, 32'h0000_6000, CTI_INCR);
        step();
        bus.slave_ack = 1'b1;
        settle();
        total++;
        if (bus.master_ack !== 2'b10) begin
            bad++;
            $display("[TB] FAIL rst_beat1 got=%b exp=10", bus.master_ack);
        end
        step();
        bus.slave_ack = 1'b0;
        setM(1, 1'b1, 1'b1, 32'h0000_6004, CTI_INCR);
        settle();
        total++;
        if (bus.slave_cyc !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rst_beat2_active got=%b exp=1", bus.slave_cyc);
        end
        #2;
        rstN = 1'b0;
        #1;
        total++;
        if (bus.slave_cyc !== 1'b0 || bus.slave_stb !== 1'b0 || bus.master_err !== 2'b00) begin
            bad++;
            $display("[TB] FAIL rst_async_drop got cyc=%b stb=%b err=%b exp 0/0/00",
                     bus.slave_cyc, bus.slave_stb, bus.master_err);
        end
        clearAll();
        setM(0, 1'b0, 1'b0, 32'h0000_7000, CTI_CLASSIC);
        setM(1, 1'b0, 1'b0, 32'h0000_6000, CTI_CLASSIC);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        settle();
        total++;
        if (bus.slave_addr !== 32'h0000_7000) begin
            bad++;
            $display("[TB] FAIL rst_grant_zero got=%h exp=00007000", bus.slave_addr);
        end
        setM(0, 1'b1, 1'b1, 32'h0000_7000, CTI_CLASSIC);
        setM(1, 1'b1, 1'b1, 32'h0000_6000, CTI_CLASSIC);
        step();
        settle();
        total++;
        if (bus.slave_cyc !== 1'b1 || bus.slave_addr !== 32'h0000_7000) begin
            bad++;
            $display("[TB] FAIL rst_ptr_zero got cyc=%b addr=%h exp 1/00007000", bus.slave_cyc, bus.slave_addr);
        end
        bus.slave_ack = 1'b1;
        step();
        bus.slave_ack = 1'b0;
        setM(0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        setM(1, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout simulation did not finish in time");
        $fatal(1, "[TB] global time limit reached");
    end

    initial begin
        test_reset();
        test_single_master();
        test_contention();
        test_burst_lock();
        test_timeout();
        test_expiry_race();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
